// File: rtl/saw_arq_receiver.sv
// Stop-and-Wait ARQ receiver.
// Accepts frames from the channel, delivers in-order payloads to the network layer and
// returns an ACK carrying the next expected sequence number (rn).
// Optional feature: define SAW_RX_NAK_EN to answer corrupted frames with a NAK instead of
// silently dropping them.
module saw_arq_receiver #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              frm_valid,
  output logic              frm_ready,
  input  logic              frm_seq,
  input  logic              frm_corrupt,
  input  logic [DATA_W-1:0] frm_data,
  output logic              dlv_valid,
  input  logic              dlv_ready,
  output logic [DATA_W-1:0] dlv_data,
  output logic              ack_valid,
  input  logic              ack_ready,
  output logic              ack_seq,
  output logic              ack_nak,
  output logic              rn,
  output logic [CNT_W-1:0]  dup_cnt,
  output logic [CNT_W-1:0]  err_cnt
);

`ifdef SAW_RX_NAK_EN
  typedef enum logic [1:0] {
    StWait    = 2'd0,
    StDeliver = 2'd1,
    StAck     = 2'd2,
    StNak     = 2'd3
  } state_e;
`else
  typedef enum logic [1:0] {
    StWait    = 2'd0,
    StDeliver = 2'd1,
    StAck     = 2'd2
  } state_e;
`endif

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  state_e             state_q, state_d;
  logic               rn_q, rn_d;
  logic [DATA_W-1:0]  dlv_data_q, dlv_data_d;
  logic [CNT_W-1:0]   dup_cnt_q, dup_cnt_d;
  logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;

  // Next-state, datapath updates and state-decoded (Moore) handshake outputs.
  always_comb begin
    state_d    = state_q;
    rn_d       = rn_q;
    dlv_data_d = dlv_data_q;
    dup_cnt_d  = dup_cnt_q;
    err_cnt_d  = err_cnt_q;
    frm_ready  = 1'b0;
    dlv_valid  = 1'b0;
    ack_valid  = 1'b0;
    ack_nak    = 1'b0;

    case (state_q)
      StWait: begin
        frm_ready = 1'b1;
        if (frm_valid) begin
          if (frm_corrupt) begin
            // Corruption wins over the sequence check: the Sn field cannot be trusted.
            if (err_cnt_q != CntMax) err_cnt_d = err_cnt_q + CntOne;
`ifdef SAW_RX_NAK_EN
            state_d = StNak;
`endif
          end else if (frm_seq == rn_q) begin
            dlv_data_d = frm_data;
            state_d    = StDeliver;
          end else begin
            // Duplicate: our previous ACK was lost, so re-ACK without delivering.
            if (dup_cnt_q != CntMax) dup_cnt_d = dup_cnt_q + CntOne;
            state_d = StAck;
          end
        end
      end
      StDeliver: begin
        dlv_valid = 1'b1;
        if (dlv_ready) begin
          // Flip rn before ACKing so the ACK names the next expected frame.
          rn_d    = ~rn_q;
          state_d = StAck;
        end
      end
      StAck: begin
        ack_valid = 1'b1;
        if (ack_ready) state_d = StWait;
      end
`ifdef SAW_RX_NAK_EN
      StNak: begin
        ack_valid = 1'b1;
        ack_nak   = 1'b1;
        if (ack_ready) state_d = StWait;
      end
`endif
      default: begin
        // Unreachable encoding: recover quietly, no outputs asserted.
        state_d = StWait;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StWait;
      rn_q       <= 1'b0;
      dlv_data_q <= '0;
      dup_cnt_q  <= '0;
      err_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      rn_q       <= rn_d;
      dlv_data_q <= dlv_data_d;
      dup_cnt_q  <= dup_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign ack_seq  = ack_valid ? rn_q : 1'b0;
  assign rn       = rn_q;
  assign dlv_data = dlv_data_q;
  assign dup_cnt  = dup_cnt_q;
  assign err_cnt  = err_cnt_q;

endmodule
